// File: rtl/float_adder_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : float_adder_param
// Description : Handshaked floating-point adder for an arbitrary
//               {sign, EXP_W exponent, MAN_W mantissa} format. There are no
//               denormals and no Inf/NaN. Results are rounded to nearest,
//               ties to even, and saturate at the largest finite value.
//               One operation is in flight at a time:
//               IDLE -> ALIGN -> NORM (1+ cycles) -> ROUND -> DONE.
// Ports       : clock, reset       - clock, asynchronous active-high reset
//               in_valid/in_ready  - operand handshake (ready only in IDLE)
//               a, b               - operands {sign, exp, man}
//               out_valid/out_ready- result handshake (valid only in DONE)
//               y                  - registered sum, held while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module float_adder_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y
);

    // Datapath layout: {carry, hidden, mantissa[MAN_W], guard, round, sticky}
    localparam int c_W      = 1 + EXP_W + MAN_W;
    localparam int c_DP_W   = MAN_W + 4;
    localparam int c_SUM_W  = MAN_W + 5;
    localparam int c_SH_MAX = MAN_W + 4;
    localparam logic [EXP_W:0] c_EXP_ONE = (EXP_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_W-1:0]        r_a;
    logic [c_W-1:0]        r_b;
    logic [c_SUM_W-1:0]    r_sum;
    logic [EXP_W:0]        r_exp;
    logic                  r_sign;
    logic [c_W-1:0]        r_y;

    // ---------------- ALIGN: order operands, align the smaller one ----------
    logic                  w_a_ge_b;
    logic [c_W-1:0]        w_big;
    logic [c_W-1:0]        w_sml;
    logic [EXP_W-1:0]      w_big_exp;
    logic [EXP_W-1:0]      w_sml_exp;
    logic [MAN_W:0]        w_big_sig;
    logic [MAN_W:0]        w_sml_sig;
    logic [31:0]           w_diff;
    logic [31:0]           w_shamt;
    logic [c_DP_W-1:0]     w_sml_ext;
    logic [c_DP_W-1:0]     w_sml_shr;
    logic [c_DP_W-1:0]     w_lost_mask;
    logic                  w_lost;
    logic [c_DP_W-1:0]     w_sml_al;
    logic [c_SUM_W-1:0]    w_add;
    logic [c_SUM_W-1:0]    w_sub;
    logic                  w_eff_sub;

    assign w_a_ge_b  = r_a[c_W-2:0] >= r_b[c_W-2:0];
    assign w_big     = w_a_ge_b ? r_a : r_b;
    assign w_sml     = w_a_ge_b ? r_b : r_a;
    assign w_big_exp = w_big[c_W-2:MAN_W];
    assign w_sml_exp = w_sml[c_W-2:MAN_W];
    // An exponent field of zero is the value zero regardless of mantissa.
    assign w_big_sig = (|w_big_exp) ? {1'b1, w_big[MAN_W-1:0]} : '0;
    assign w_sml_sig = (|w_sml_exp) ? {1'b1, w_sml[MAN_W-1:0]} : '0;
    // Magnitude ordering guarantees big exponent >= small exponent.
    assign w_diff    = 32'(w_big_exp) - 32'(w_sml_exp);
    assign w_shamt   = (w_diff > 32'(c_SH_MAX)) ? 32'(c_SH_MAX) : w_diff;
    assign w_sml_ext = {w_sml_sig, 3'b000};
    assign w_sml_shr = w_sml_ext >> w_shamt;
    // Every bit shifted out of the datapath collapses into sticky.
    assign w_lost_mask = ~({c_DP_W{1'b1}} << w_shamt);
    assign w_lost    = |(w_sml_ext & w_lost_mask);
    assign w_sml_al  = {w_sml_shr[c_DP_W-1:1], w_sml_shr[0] | w_lost};
    assign w_add     = {1'b0, w_big_sig, 3'b000} + {1'b0, w_sml_al};
    assign w_sub     = {1'b0, w_big_sig, 3'b000} - {1'b0, w_sml_al};
    assign w_eff_sub = r_a[c_W-1] ^ r_b[c_W-1];

    // ---------------- NORM decisions ----------------------------------------
    logic                  w_is_zero;
    logic                  w_carry;
    logic                  w_hid;
    logic                  w_flush;

    assign w_is_zero = (r_sum == '0);
    assign w_carry   = r_sum[c_SUM_W-1];
    assign w_hid     = r_sum[c_SUM_W-2];
    // Left shift would take the exponent to zero: there are no denormals.
    assign w_flush   = !w_is_zero && !w_carry && !w_hid && (r_exp == c_EXP_ONE);

    // ---------------- ROUND: nearest-even on guard/round/sticky -------------
    logic [MAN_W-1:0]      w_man;
    logic                  w_rup;
    logic [MAN_W:0]        w_man_inc;
    logic [EXP_W:0]        w_exp_rnd;
    logic [c_W-1:0]        w_y_rnd;

    assign w_man     = r_sum[c_DP_W-2:3];
    assign w_rup     = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
    assign w_man_inc = {1'b0, w_man} + {{MAN_W{1'b0}}, w_rup};
    // Mantissa overflow leaves the low bits at zero and bumps the exponent.
    assign w_exp_rnd = r_exp + {{EXP_W{1'b0}}, w_man_inc[MAN_W]};
    assign w_y_rnd   = w_exp_rnd[EXP_W] ? {r_sign, {(c_W-1){1'b1}}}
                                        : {r_sign, w_exp_rnd[EXP_W-1:0], w_man_inc[MAN_W-1:0]};

    // ---------------- FSM ----------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_ALIGN;
            end
            S_ALIGN: w_next = S_NORM;
            S_NORM: begin
                if (w_is_zero || w_flush)  w_next = S_ROUND;
                else if (w_carry || !w_hid) w_next = S_NORM;
                else                        w_next = S_ROUND;
            end
            S_ROUND: w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- Datapath registers -------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_y    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                S_ALIGN: begin
                    r_sum  <= w_eff_sub ? w_sub : w_add;
                    r_exp  <= {1'b0, w_big_exp};
                    r_sign <= w_big[c_W-1];
                end
                S_NORM: begin
                    if (w_is_zero) begin
                        // Only -0 + -0 keeps a negative zero; cancellation is +0.
                        r_exp  <= '0;
                        r_sign <= r_a[c_W-1] & r_b[c_W-1];
                    end else if (w_carry) begin
                        r_sum <= {1'b0, r_sum[c_SUM_W-1:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + c_EXP_ONE;
                    end else if (w_flush) begin
                        r_sum  <= '0;
                        r_exp  <= '0;
                        r_sign <= 1'b0;
                    end else if (!w_hid) begin
                        r_sum <= r_sum << 1;
                        r_exp <= r_exp - c_EXP_ONE;
                    end
                end
                S_ROUND: r_y <= w_y_rnd;
                default: ;
            endcase
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_float_adder_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_float_adder_param
// Description : Self-checking bench for float_adder_param (bf16 and e4m3
//               instances). Expected results and latencies are queued when
//               operands are issued and compared when out_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_adder_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv16 = 1'b0, ir16, ov16;
    logic [15:0] a16 = '0, b16 = '0, y16;
    logic        iv8 = 1'b0, ir8, ov8;
    logic [7:0]  a8 = '0, b8 = '0, y8;
    logic        ordy = 1'b0;
    logic        sel8 = 1'b0;

    float_adder_param u_bf16 (
        .clock(clk), .reset(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(ordy), .y(y16)
    );

    float_adder_param #(.EXP_W(4), .MAN_W(3)) u_e4m3 (
        .clock(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy), .y(y8)
    );

    logic        cur_ov, cur_ir;
    logic [15:0] cur_y;
    always_comb begin
        cur_ov = sel8 ? ov8 : ov16;
        cur_ir = sel8 ? ir8 : ir16;
        cur_y  = sel8 ? {8'h00, y8} : y16;
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [15:0] y; int lat; } exp_t;
    exp_t sb_q[$];

    typedef struct { string name; logic [15:0] a; logic [15:0] b; logic [15:0] y; int k; } vec_t;
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Present operands for one cycle; returns 1 ns after the accepting edge.
    task automatic issue(input logic [15:0] ai, input logic [15:0] bi,
                         input logic [15:0] yi, input int k);
        exp_t e;
        @(negedge clk);
        if (sel8) begin a8 = ai[7:0]; b8 = bi[7:0]; iv8 = 1'b1; end
        else      begin a16 = ai; b16 = bi; iv16 = 1'b1; end
        e.y = yi; e.lat = 3 + k;
        sb_q.push_back(e);
        @(posedge clk); #1;
        iv8 = 1'b0; iv16 = 1'b0;
        // Garbage on the operand bus while busy must not matter.
        a16 = 16'hFFFF; b16 = 16'h1234; a8 = 8'hFF; b8 = 8'h5A;
    endtask

    task automatic wait_result(input string nm);
        exp_t e;
        int   cyc = 0;
        bit   busy_ok = 1'b1;
        if (cur_ir) busy_ok = 1'b0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cur_ir) busy_ok = 1'b0;
        end while (!cur_ov && cyc < 60);
        chk({nm, " out_valid"}, {31'd0, cur_ov}, 32'd1);
        if (sb_q.size() == 0) begin
            chk({nm, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({nm, " latency"}, cyc, e.lat);
            chk({nm, " y"}, {16'd0, cur_y}, {16'd0, e.y});
        end
        chk({nm, " in_ready low while busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic release_out(input string nm);
        @(negedge clk); ordy = 1'b1;
        @(posedge clk); #1; ordy = 1'b0;
        chk({nm, " in_ready after handshake"}, {31'd0, cur_ir}, 32'd1);
        chk({nm, " out_valid after handshake"}, {31'd0, cur_ov}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] y_hold;
        // k = number of NORM shifts, derived by hand from the operand values.
        vecs[0]  = '{"1+2",          16'h3F80, 16'h4000, 16'h4040, 0};
        vecs[1]  = '{"2+1",          16'h4000, 16'h3F80, 16'h4040, 0};
        vecs[2]  = '{"cancel",       16'h3F80, 16'hBF80, 16'h0000, 0};
        vecs[3]  = '{"3-1",          16'h4040, 16'hBF80, 16'h4000, 0};
        vecs[4]  = '{"-3+1",         16'hC040, 16'h3F80, 16'hC000, 0};
        vecs[5]  = '{"near cancel",  16'h3F81, 16'hBF80, 16'h3C00, 7};
        vecs[6]  = '{"tie even",     16'h3F80, 16'h3B80, 16'h3F80, 0};
        vecs[7]  = '{"above half",   16'h3F80, 16'h3BC0, 16'h3F81, 0};
        vecs[8]  = '{"round carry",  16'h3FFF, 16'h3B80, 16'h4000, 0};
        vecs[9]  = '{"saturate",     16'h7FFF, 16'h7FFF, 16'h7FFF, 1};
        vecs[10] = '{"0+(-2)",       16'h0000, 16'hC000, 16'hC000, 0};
        vecs[11] = '{"-0+-0",        16'h8000, 16'h8000, 16'h8000, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, ir16}, 32'd1);
        chk("reset out_valid", {31'd0, ov16}, 32'd0);
        chk("reset y", {16'd0, y16}, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].k);
            wait_result(vecs[i].name);
            release_out(vecs[i].name);
        end

        // Exponent 1 minus nearly-equal value: first left shift flushes to +0.
        issue(16'h0081, 16'h8080, 16'h0000, 0);
        wait_result("underflow flush");
        release_out("underflow flush");

        // Back-pressure with an early second operand.
        issue(16'h4000, 16'h4000, 16'h4080, 1);
        wait_result("bp first");
        y_hold = y16;
        @(negedge clk);
        a16 = 16'h3F80; b16 = 16'h4000; iv16 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp out_valid held", {31'd0, ov16}, 32'd1);
            chk("bp y held", {16'd0, y16}, {16'd0, y_hold});
            chk("bp in_ready low", {31'd0, ir16}, 32'd0);
        end
        @(negedge clk); ordy = 1'b1;
        @(posedge clk); #1; ordy = 1'b0;
        chk("bp in_ready after pulse", {31'd0, ir16}, 32'd1);
        begin
            exp_t e;
            e.y = 16'h4040; e.lat = 3;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h1234;
        wait_result("bp second");
        release_out("bp second");

        // Reset in the middle of a long NORM phase.
        issue(16'h3F81, 16'hBF80, 16'h3C00, 7);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1; #1;
        chk("mid reset out_valid", {31'd0, ov16}, 32'd0);
        chk("mid reset y", {16'd0, y16}, 32'd0);
        chk("mid reset in_ready", {31'd0, ir16}, 32'd1);
        void'(sb_q.pop_back());
        @(negedge clk); rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("no result after reset", {31'd0, ov16}, 32'd0);
        issue(16'h3F80, 16'h4000, 16'h4040, 0);
        wait_result("after reset");
        release_out("after reset");

        // e4m3 instance.
        sel8 = 1'b1;
        issue(16'h0038, 16'h0038, 16'h0040, 1);
        wait_result("e4m3 1+1");
        release_out("e4m3 1+1");
        issue(16'h007F, 16'h007F, 16'h007F, 1);
        wait_result("e4m3 saturate");
        release_out("e4m3 saturate");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
